// File: rtl/hbuf_pkg.sv
// ----------------------------------------------------------------------------
// hbuf_pkg
// Shared definitions for the hit buffer readout path: the readout DPRAM
// geometry and the state encoding of the readout feeder FSM.
// No ports (package).
// ----------------------------------------------------------------------------
package hbuf_pkg;

    // Readout DPRAM is addressed in 32-bit words.
    localparam int HBUF_RDOUT_ADDR_W  = 10;
    localparam int HBUF_RDOUT_MAX_W32 = 1 << HBUF_RDOUT_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRAIN = 3'd2,
        S_RUN   = 3'd3,
        S_ACK   = 3'd4,
        S_DONE  = 3'd5
    } hbuf_rdout_state_e;

endpackage

// File: rtl/hbuf_rdout_feeder_if.sv
// ----------------------------------------------------------------------------
// hbuf_rdout_feeder_if
// Groups the feeder's handshake and bus signals.
//   en                  enable (low = synchronous abort)
//   src_valid/data/last FWFT 16-bit packet source, src_rdreq consumes a word
//   dpram_wren/wr_addr/data  readout DPRAM write port
//   dpram_len/run       packet hand-off to the hit buffer controller
//   dpram_busy          controller owns the DPRAM
//   pkt_cnt/trunc_err   status
// Modports: master = the feeder, slave = its environment.
// ----------------------------------------------------------------------------
interface hbuf_rdout_feeder_if #(
    parameter int ADDR_W = 10
);
    logic              en;
    logic              src_valid;
    logic [15:0]       src_data;
    logic              src_last;
    logic              src_rdreq;
    logic              dpram_wren;
    logic [ADDR_W-1:0] dpram_wr_addr;
    logic [31:0]       dpram_data;
    logic [15:0]       dpram_len;
    logic              dpram_run;
    logic              dpram_busy;
    logic [31:0]       pkt_cnt;
    logic              trunc_err;

    modport master (
        input  en, src_valid, src_data, src_last, dpram_busy,
        output src_rdreq, dpram_wren, dpram_wr_addr, dpram_data,
               dpram_len, dpram_run, pkt_cnt, trunc_err
    );

    modport slave (
        output en, src_valid, src_data, src_last, dpram_busy,
        input  src_rdreq, dpram_wren, dpram_wr_addr, dpram_data,
               dpram_len, dpram_run, pkt_cnt, trunc_err
    );
endinterface

// File: rtl/hbuf_rdout_feeder.sv
// ----------------------------------------------------------------------------
// hbuf_rdout_feeder
// Upstream stage of the hit buffer controller. Pulls one packet at a time
// from a FWFT 16-bit source, packs pairs of words into 32-bit DPRAM writes
// (first word in the low half), then hands the packet off with a length and
// a one-cycle run pulse. The next packet is not started until the controller
// has taken the DPRAM (busy high) and released it again (busy low).
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous, active-high reset
//   bus  hbuf_rdout_feeder_if.master (source, DPRAM write port, hand-off,
//        status; see the interface file)
// ----------------------------------------------------------------------------
module hbuf_rdout_feeder
    import hbuf_pkg::*;
#(
    parameter int ADDR_W  = HBUF_RDOUT_ADDR_W,
    parameter int MAX_W32 = HBUF_RDOUT_MAX_W32
) (
    input  logic                clk,
    input  logic                rst,
    hbuf_rdout_feeder_if.master bus
);

    // Word counter must be able to hold MAX_W32 itself.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_W32 - 1);

    hbuf_rdout_state_e state_q, state_d;

    logic [15:0]       lowHalf_q, lowHalf_d;
    logic              haveLow_q, haveLow_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [CNT_W-1:0]  wordCnt_q, wordCnt_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wrAddrOut_q, wrAddrOut_d;
    logic [31:0]       data_q, data_d;
    logic [15:0]       len_q, len_d;
    logic              run_q, run_d;
    logic [31:0]       pktCnt_q, pktCnt_d;
    logic              truncErr_q, truncErr_d;

    logic              srcRdreq;
    logic              writeNow;
    logic [31:0]       writeWord;

    // A word is taken whenever the FSM is collecting or discarding and the
    // source has one; at most one word per cycle.
    assign srcRdreq = ((state_q == S_FILL) || (state_q == S_DRAIN)) && bus.src_valid;

    // Next-state and datapath. A write is issued on the odd word of a pair,
    // or on an even word carrying last (zero upper half). Hitting the last
    // DPRAM address without last truncates the packet and drains the rest.
    always_comb begin
        state_d     = state_q;
        lowHalf_d   = lowHalf_q;
        haveLow_d   = haveLow_q;
        wrAddr_d    = wrAddr_q;
        wordCnt_d   = wordCnt_q;
        wren_d      = 1'b0;
        wrAddrOut_d = wrAddrOut_q;
        data_d      = data_q;
        len_d       = len_q;
        run_d       = 1'b0;
        pktCnt_d    = pktCnt_q;
        truncErr_d  = truncErr_q;
        writeNow    = 1'b0;
        writeWord   = 32'h0;

        if (!bus.en) begin
            state_d     = S_IDLE;
            lowHalf_d   = 16'h0;
            haveLow_d   = 1'b0;
            wrAddr_d    = '0;
            wordCnt_d   = '0;
            wrAddrOut_d = '0;
            data_d      = 32'h0;
            len_d       = 16'h0;
            pktCnt_d    = 32'h0;
            truncErr_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    haveLow_d = 1'b0;
                    wrAddr_d  = '0;
                    wordCnt_d = '0;
                    if (bus.src_valid) begin
                        state_d = S_FILL;
                    end
                end

                S_FILL: begin
                    if (srcRdreq) begin
                        if (haveLow_q) begin
                            writeNow  = 1'b1;
                            writeWord = {bus.src_data, lowHalf_q};
                            haveLow_d = 1'b0;
                        end else if (bus.src_last) begin
                            writeNow  = 1'b1;
                            writeWord = {16'h0000, bus.src_data};
                        end else begin
                            lowHalf_d = bus.src_data;
                            haveLow_d = 1'b1;
                        end

                        if (writeNow) begin
                            wren_d      = 1'b1;
                            wrAddrOut_d = wrAddr_q;
                            data_d      = writeWord;
                            wrAddr_d    = wrAddr_q + 1'b1;
                            wordCnt_d   = wordCnt_q + 1'b1;
                        end

                        if (bus.src_last) begin
                            state_d = S_RUN;
                        end else if (writeNow && (wrAddr_q == LAST_ADDR)) begin
                            truncErr_d = 1'b1;
                            state_d    = S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (srcRdreq && bus.src_last) begin
                        state_d = S_RUN;
                    end
                end

                S_RUN: begin
                    // Length in 16-bit words; an odd count was already
                    // rounded up by the zero-padded final write.
                    len_d    = 16'({wordCnt_q, 1'b0});
                    run_d    = 1'b1;
                    pktCnt_d = pktCnt_q + 32'd1;
                    state_d  = S_ACK;
                end

                S_ACK: begin
                    if (bus.dpram_busy) begin
                        state_d = S_DONE;
                    end
                end

                S_DONE: begin
                    if (!bus.dpram_busy) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lowHalf_q   <= 16'h0;
            haveLow_q   <= 1'b0;
            wrAddr_q    <= '0;
            wordCnt_q   <= '0;
            wren_q      <= 1'b0;
            wrAddrOut_q <= '0;
            data_q      <= 32'h0;
            len_q       <= 16'h0;
            run_q       <= 1'b0;
            pktCnt_q    <= 32'h0;
            truncErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lowHalf_q   <= lowHalf_d;
            haveLow_q   <= haveLow_d;
            wrAddr_q    <= wrAddr_d;
            wordCnt_q   <= wordCnt_d;
            wren_q      <= wren_d;
            wrAddrOut_q <= wrAddrOut_d;
            data_q      <= data_d;
            len_q       <= len_d;
            run_q       <= run_d;
            pktCnt_q    <= pktCnt_d;
            truncErr_q  <= truncErr_d;
        end
    end

    assign bus.src_rdreq     = srcRdreq;
    assign bus.dpram_wren    = wren_q;
    assign bus.dpram_wr_addr = wrAddrOut_q;
    assign bus.dpram_data    = data_q;
    assign bus.dpram_len     = len_q;
    assign bus.dpram_run     = run_q;
    assign bus.pkt_cnt       = pktCnt_q;
    assign bus.trunc_err     = truncErr_q;

endmodule

// File: tb/tb_hbuf_rdout_feeder.sv
// ----------------------------------------------------------------------------
// tb_hbuf_rdout_feeder
// Scoreboard bench for hbuf_rdout_feeder: packets are pushed into a source
// model together with their expected DPRAM writes and hand-offs; monitors
// pop and compare when the DUT writes or pulses run. A responder models the
// controller's busy handshake.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hbuf_rdout_feeder;
    import hbuf_pkg::*;

    typedef struct packed {
        logic [15:0] len;
        logic [31:0] cnt;
        logic        trunc;
    } runExp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hbuf_rdout_feeder_if #(.ADDR_W(10)) busIf();

    hbuf_rdout_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.master)
    );

    int      compareCount  = 0;
    int      mismatchCount = 0;
    logic [16:0] srcQ[$];
    logic [41:0] expWrQ[$];
    runExp_t     expRunQ[$];
    int      expPktCnt  = 0;
    bit      expTrunc   = 1'b0;
    bit      srcToggle  = 1'b0;
    bit      srcPhase   = 1'b0;
    bit      busyActive = 1'b0;
    int      busyHold   = 20;

    // One comparison: count it, report a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Queue a packet in the source and record what the DUT should do with it.
    task automatic applyStimulus(input int nWords, input logic [15:0] base,
                                 input logic [15:0] step, input bit withLast);
        logic [15:0] w[$];
        logic [15:0] hi;
        int nWrites;
        bit trunc;
        for (int i = 0; i < nWords; i++) begin
            w.push_back(base + step * 16'(i));
            srcQ.push_back({(withLast && (i == nWords - 1)), w[i]});
        end
        nWrites = withLast ? (nWords + 1) / 2 : nWords / 2;
        trunc = 1'b0;
        if (nWrites > 1024) begin
            nWrites = 1024;
            trunc   = 1'b1;
        end
        for (int k = 0; k < nWrites; k++) begin
            hi = (2 * k + 1 < nWords) ? w[2 * k + 1] : 16'h0000;
            expWrQ.push_back({10'(k), hi, w[2 * k]});
        end
        if (withLast) begin
            expPktCnt++;
            if (trunc) expTrunc = 1'b1;
            expRunQ.push_back('{len: 16'(2 * nWrites), cnt: 32'(expPktCnt), trunc: expTrunc});
        end
    endtask

    // Wait until all queued work is consumed and the busy handshake is over.
    task automatic waitDrain(input int budget, input string tag);
        int n;
        n = 0;
        while ((expWrQ.size() != 0 || expRunQ.size() != 0 || srcQ.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        while ((busyActive || busIf.dpram_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "Timeout"}, 64'(n >= budget), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // FWFT source model: pops the head word after a cycle in which it was taken.
    initial begin
        bit took;
        busIf.src_valid = 1'b0;
        busIf.src_data  = 16'h0;
        busIf.src_last  = 1'b0;
        forever begin
            @(negedge clk);
            took = busIf.src_rdreq && busIf.src_valid;
            @(posedge clk);
            #1;
            if (took && srcQ.size() != 0) void'(srcQ.pop_front());
            srcPhase = ~srcPhase;
            busIf.src_valid = (srcQ.size() != 0) && (!srcToggle || srcPhase);
            busIf.src_data  = (srcQ.size() != 0) ? srcQ[0][15:0] : 16'h0;
            busIf.src_last  = (srcQ.size() != 0) ? srcQ[0][16] : 1'b0;
        end
    end

    // Controller model: busy rises one cycle after run and is held for busyHold cycles.
    initial begin
        busIf.dpram_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busIf.dpram_run === 1'b1) begin
                busyActive = 1'b1;
                @(posedge clk);
                #1 busIf.dpram_busy = 1'b1;
                repeat (busyHold) @(posedge clk);
                #1 busIf.dpram_busy = 1'b0;
                busyActive = 1'b0;
            end
        end
    end

    // Output monitor: compares every write and every hand-off against the scoreboard.
    initial begin
        logic [41:0] we;
        runExp_t     re;
        forever begin
            @(negedge clk);
            if (busIf.dpram_wren === 1'b1) begin
                checkOutput("wrenWhileBusy", 64'(busIf.dpram_busy), 64'd0);
                checkOutput("wrExpected", 64'(expWrQ.size() != 0), 64'd1);
                if (expWrQ.size() != 0) begin
                    we = expWrQ.pop_front();
                    checkOutput("wrAddr", 64'(busIf.dpram_wr_addr), 64'(we[41:32]));
                    checkOutput("wrData", 64'(busIf.dpram_data), 64'(we[31:0]));
                end
            end
            if (busIf.dpram_run === 1'b1) begin
                checkOutput("runExpected", 64'(expRunQ.size() != 0), 64'd1);
                if (expRunQ.size() != 0) begin
                    re = expRunQ.pop_front();
                    checkOutput("runLen", 64'(busIf.dpram_len), 64'(re.len));
                    checkOutput("runPktCnt", 64'(busIf.pkt_cnt), 64'(re.cnt));
                    checkOutput("runTrunc", 64'(busIf.trunc_err), 64'(re.trunc));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int offset;
        int rdreqDuringBusy;

        rst      = 1'b1;
        busIf.en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstRdreq", 64'(busIf.src_rdreq), 64'd0);
        checkOutput("rstWren", 64'(busIf.dpram_wren), 64'd0);
        checkOutput("rstRun", 64'(busIf.dpram_run), 64'd0);
        checkOutput("rstLen", 64'(busIf.dpram_len), 64'd0);
        checkOutput("rstPktCnt", 64'(busIf.pkt_cnt), 64'd0);
        checkOutput("rstTrunc", 64'(busIf.trunc_err), 64'd0);
        checkOutput("rstAddr", 64'(busIf.dpram_wr_addr), 64'd0);
        checkOutput("rstData", 64'(busIf.dpram_data), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        busIf.en = 1'b1;

        $display("[TB] basic packet and busy handshake");
        applyStimulus(3, 16'h1111, 16'h1111, 1'b1);
        applyStimulus(2, 16'hA000, 16'h0001, 1'b1);
        n = 0;
        while (busIf.dpram_busy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busyRiseTimeout", 64'(n >= 200), 64'd0);
        rdreqDuringBusy = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (busIf.dpram_busy !== 1'b1) break;
            if (busIf.src_rdreq === 1'b1) rdreqDuringBusy++;
        end
        checkOutput("rdreqDuringBusy", 64'(rdreqDuringBusy), 64'd0);
        offset = 0;
        while (busIf.src_rdreq !== 1'b1 && offset < 10) begin
            @(negedge clk);
            offset++;
        end
        checkOutput("busyFallToRdreq", 64'(offset), 64'd2);
        waitDrain(400, "basic");

        $display("[TB] exact-fit packet");
        applyStimulus(2048, 16'h0100, 16'h0001, 1'b1);
        waitDrain(5000, "exactFit");
        checkOutput("exactFitNoTrunc", 64'(busIf.trunc_err), 64'd0);

        $display("[TB] oversize packet and sticky truncation");
        applyStimulus(2050, 16'h4000, 16'h0001, 1'b1);
        applyStimulus(4, 16'h5000, 16'h0001, 1'b1);
        waitDrain(6000, "oversize");
        checkOutput("truncSticky", 64'(busIf.trunc_err), 64'd1);

        $display("[TB] gapped source");
        srcToggle = 1'b1;
        applyStimulus(8, 16'h6000, 16'h0101, 1'b1);
        waitDrain(400, "gapped");
        srcToggle = 1'b0;

        $display("[TB] enable abort mid-packet");
        applyStimulus(5, 16'h7000, 16'h0001, 1'b0);
        waitDrain(400, "partial");
        @(posedge clk);
        #1 busIf.en = 1'b0;
        expPktCnt = 0;
        expTrunc  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abortPktCnt", 64'(busIf.pkt_cnt), 64'd0);
        checkOutput("abortTrunc", 64'(busIf.trunc_err), 64'd0);
        checkOutput("abortLen", 64'(busIf.dpram_len), 64'd0);
        checkOutput("abortRdreq", 64'(busIf.src_rdreq), 64'd0);
        @(posedge clk);
        #1 busIf.en = 1'b1;
        applyStimulus(2, 16'h7100, 16'h0001, 1'b1);
        waitDrain(400, "afterAbort");

        $display("[TB] asynchronous reset mid-fill");
        applyStimulus(3, 16'h8000, 16'h0001, 1'b0);
        n = 0;
        while (busIf.dpram_wren !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fillWrenTimeout", 64'(n >= 100), 64'd0);
        #2 rst = 1'b1;
        expPktCnt = 0;
        expTrunc  = 1'b0;
        #1;
        checkOutput("asyncWren", 64'(busIf.dpram_wren), 64'd0);
        checkOutput("asyncData", 64'(busIf.dpram_data), 64'd0);
        checkOutput("asyncPktCnt", 64'(busIf.pkt_cnt), 64'd0);
        checkOutput("asyncLen", 64'(busIf.dpram_len), 64'd0);
        checkOutput("asyncRdreq", 64'(busIf.src_rdreq), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        applyStimulus(1, 16'h9000, 16'h0000, 1'b1);
        applyStimulus(1, 16'h9001, 16'h0000, 1'b1);
        applyStimulus(1, 16'h9002, 16'h0000, 1'b1);
        waitDrain(600, "singleWord");
        checkOutput("finalPktCnt", 64'(busIf.pkt_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
